// File: rtl/bcd_digit_conv_pkg.sv
// Shared display package: converter FSM states, nibble type,
// and the digit-count sufficiency check used by display blocks.
package bcd_digit_conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef logic [3:0] nibble_t;

  // True when DIGITS decimal digits can hold any WIDTH-bit value
  function automatic bit digits_ok(input int width, input int digits);
    longint maxv;
    longint p;
    maxv = (longint'(1) << width) - 1;
    p    = 1;
    for (int i = 0; i < digits; i++) begin
      p = p * 10;
      if (p > maxv) return 1'b1;
    end
    return (p > maxv);
  endfunction

endpackage

// File: rtl/bcd_digit_conv_if.sv
// Request/result bundle between the display register and
// the binary-to-BCD converter.
interface bcd_digit_conv_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  iSTART;
  logic [WIDTH-1:0]      iBIN;
  logic                  oBUSY;
  logic                  oDONE;
  logic [4*DIGITS-1:0]   oDIGITS;
  logic [DIGITS-1:0]     oBLANK;

  modport master (
    output iSTART, iBIN,
    input  oBUSY, oDONE, oDIGITS, oBLANK
  );

  modport slave (
    input  iSTART, iBIN,
    output oBUSY, oDONE, oDIGITS, oBLANK
  );
endinterface

// File: rtl/bcd_digit_conv_add3.sv
// Double-dabble nibble adjust: add 3 when the nibble is 5 or more.
module bcd_add3
  import bcd_digit_conv_pkg::*;
(
  input  nibble_t in_i,
  output nibble_t out_o
);

  assign out_o = (in_i >= 4'd5) ? in_i + 4'd3 : in_i;

endmodule

// File: rtl/bcd_digit_conv.sv
// Iterative binary-to-BCD converter with leading-zero blank flags,
// results held stable until the next conversion completes.
module bcd_digit_conv
  import bcd_digit_conv_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  bcd_digit_conv_if.slave   bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  if (WIDTH < 4 || WIDTH > 32 || !digits_ok(WIDTH, DIGITS)) begin : g_bad
    $error("bcd_digit_conv: bad WIDTH/DIGITS combination");
  end

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] bin_d;
  logic [BW-1:0]   bcd_q;
  logic [BW-1:0]   bcd_adj;
  logic [BW-1:0]   bcd_d;
  logic [BW-1:0]   digits_q;
  logic [DIGITS-1:0] blank_q;
  logic [DIGITS-1:0] blank_d;
  logic            busy_q;
  logic            done_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_add3 u_add3 (
      .in_i  (bcd_q[4*g +: 4]),
      .out_o (bcd_adj[4*g +: 4])
    );
  end

  // Top bit shifted out is always zero given enough digits
  assign {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;

  always_comb begin
    logic z;
    blank_d = '0;
    z = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      z = z & (bcd_d[4*k +: 4] == 4'd0);
      blank_d[k] = z;
    end
    blank_d[0] = 1'b0;
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bin_q    <= '0;
      bcd_q    <= '0;
      digits_q <= '0;
      blank_q  <= {{(DIGITS-1){1'b1}}, 1'b0};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus.iSTART) begin
            bin_q   <= bus.iBIN;
            bcd_q   <= '0;
            cnt_q   <= CW'(WIDTH);
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          bin_q <= bin_d;
          bcd_q <= bcd_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            digits_q <= bcd_d;
            blank_q  <= blank_d;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.oBUSY   = busy_q;
  assign bus.oDONE   = done_q;
  assign bus.oDIGITS = digits_q;
  assign bus.oBLANK  = blank_q;

endmodule

// File: tb/tb_bcd_digit_conv.sv
// Directed-vector bench for the binary-to-BCD converter.
// Each task drives one scenario and checks results inline.
module tb_bcd_digit_conv;

  logic clk;
  logic rst_n;
  int   applied;
  int   miscompares;

  bcd_digit_conv_if #(.WIDTH(16), .DIGITS(5)) bus ();

  bcd_digit_conv #(.WIDTH(16), .DIGITS(5)) dut (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts a conversion from IDLE and waits (bounded) for oDONE.
  // pulse_at >= 0 re-asserts iSTART with pulse_v at that cycle.
  task automatic convert(
    input  logic [15:0] v,
    input  int          pulse_at,
    input  logic [15:0] pulse_v,
    output logic [19:0] dig,
    output logic [4:0]  blk,
    output int          lat,
    output int          busy_n,
    output int          held_bad,
    output int          overlap
  );
    logic [19:0] prev;
    prev = bus.oDIGITS;
    bus.iBIN = v;
    bus.iSTART = 1'b1;
    @(posedge clk); #1;
    bus.iSTART = 1'b0;
    bus.iBIN = ~v;
    lat = 0;
    busy_n = 0;
    held_bad = 0;
    overlap = 0;
    while (bus.oDONE !== 1'b1 && lat < 40) begin
      if (bus.oBUSY === 1'b1) busy_n++;
      if (bus.oDIGITS !== prev) held_bad++;
      if (lat == pulse_at) begin
        bus.iSTART = 1'b1;
        bus.iBIN = pulse_v;
      end else begin
        bus.iSTART = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.iSTART = 1'b0;
    if (bus.oBUSY === 1'b1) overlap++;
    dig = bus.oDIGITS;
    blk = bus.oBLANK;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.iSTART = 1'b0;
    bus.iBIN = '0;
    repeat (3) @(posedge clk);
    #1;
    applied++;
    if (bus.oDIGITS !== 20'h00000) begin
      miscompares++;
      $display("FAIL reset_digits got %h want %h", bus.oDIGITS, 20'h00000);
    end
    applied++;
    if (bus.oBLANK !== 5'b11110) begin
      miscompares++;
      $display("FAIL reset_blank got %b want %b", bus.oBLANK, 5'b11110);
    end
    applied++;
    if (bus.oBUSY !== 1'b0 || bus.oDONE !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags got busy=%b done=%b want 0/0", bus.oBUSY, bus.oDONE);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    logic [19:0] d;
    logic [4:0]  b;
    int l, bn, hb, ov;
    convert(16'd0, -1, 16'd0, d, b, l, bn, hb, ov);
    applied++;
    if (l !== 16) begin
      miscompares++;
      $display("FAIL zero_latency got %0d want 16", l);
    end
    applied++;
    if (d !== 20'h00000) begin
      miscompares++;
      $display("FAIL zero_digits got %h want %h", d, 20'h00000);
    end
    applied++;
    if (b !== 5'b11110) begin
      miscompares++;
      $display("FAIL zero_blank got %b want %b", b, 5'b11110);
    end
    @(posedge clk); #1;
    applied++;
    if (bus.oDONE !== 1'b0) begin
      miscompares++;
      $display("FAIL done_pulse_width got %b want 0", bus.oDONE);
    end
  endtask

  task automatic test_1234();
    logic [19:0] d;
    logic [4:0]  b;
    int l, bn, hb, ov;
    convert(16'd1234, -1, 16'd0, d, b, l, bn, hb, ov);
    applied++;
    if (d !== 20'h01234) begin
      miscompares++;
      $display("FAIL d1234_digits got %h want %h", d, 20'h01234);
    end
    applied++;
    if (b !== 5'b10000) begin
      miscompares++;
      $display("FAIL d1234_blank got %b want %b", b, 5'b10000);
    end
    applied++;
    if (bn !== 16) begin
      miscompares++;
      $display("FAIL d1234_busy_cycles got %0d want 16", bn);
    end
    applied++;
    if (ov !== 0) begin
      miscompares++;
      $display("FAIL d1234_busy_done_overlap got %0d want 0", ov);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_max();
    logic [19:0] d;
    logic [4:0]  b;
    int l, bn, hb, ov;
    convert(16'd65535, -1, 16'd0, d, b, l, bn, hb, ov);
    applied++;
    if (d !== 20'h65535) begin
      miscompares++;
      $display("FAIL max_digits got %h want %h", d, 20'h65535);
    end
    applied++;
    if (b !== 5'b00000) begin
      miscompares++;
      $display("FAIL max_blank got %b want %b", b, 5'b00000);
    end
    applied++;
    if (hb !== 0) begin
      miscompares++;
      $display("FAIL max_held_during_shift got %0d changes want 0", hb);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_restart();
    logic [19:0] d;
    logic [4:0]  b;
    int l, bn, hb, ov;
    convert(16'd7, 5, 16'd9999, d, b, l, bn, hb, ov);
    applied++;
    if (d !== 20'h00007) begin
      miscompares++;
      $display("FAIL ignore_digits got %h want %h", d, 20'h00007);
    end
    applied++;
    if (b !== 5'b11110) begin
      miscompares++;
      $display("FAIL ignore_blank got %b want %b", b, 5'b11110);
    end
    applied++;
    if (l !== 16) begin
      miscompares++;
      $display("FAIL ignore_latency got %0d want 16", l);
    end
    repeat (2) @(posedge clk);
    #1;
    applied++;
    if (bus.oBUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_not_queued got busy=%b want 0", bus.oBUSY);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bus.iBIN = 16'd42;
    bus.iSTART = 1'b1;
    @(posedge clk); #1;
    bus.iBIN = 16'd555;
    n = 0;
    while (bus.oDONE !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    applied++;
    if (bus.oDIGITS !== 20'h00042 || bus.oBLANK !== 5'b11100) begin
      miscompares++;
      $display("FAIL b2b_first got %h/%b want %h/%b",
               bus.oDIGITS, bus.oBLANK, 20'h00042, 5'b11100);
    end
    bus.iBIN = 16'd100;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) bus.iBIN = 16'd777;
    end while (bus.oDONE !== 1'b1 && n < 40);
    applied++;
    if (n !== 17) begin
      miscompares++;
      $display("FAIL b2b_period got %0d want 17", n);
    end
    applied++;
    if (bus.oDIGITS !== 20'h00100 || bus.oBLANK !== 5'b11000) begin
      miscompares++;
      $display("FAIL b2b_second got %h/%b want %h/%b",
               bus.oDIGITS, bus.oBLANK, 20'h00100, 5'b11000);
    end
    bus.iSTART = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    applied++;
    if (bus.oBUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_stop got busy=%b want 0", bus.oBUSY);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [19:0] d;
    logic [4:0]  b;
    int l, bn, hb, ov;
    int seen;
    bus.iBIN = 16'd500;
    bus.iSTART = 1'b1;
    @(posedge clk); #1;
    bus.iSTART = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    applied++;
    if (bus.oBUSY !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_busy_before got %b want 1", bus.oBUSY);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    applied++;
    if (bus.oDIGITS !== 20'h00000 || bus.oBLANK !== 5'b11110) begin
      miscompares++;
      $display("FAIL rst_mid_outputs got %h/%b want %h/%b",
               bus.oDIGITS, bus.oBLANK, 20'h00000, 5'b11110);
    end
    applied++;
    if (bus.oBUSY !== 1'b0 || bus.oDONE !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_flags got busy=%b done=%b want 0/0", bus.oBUSY, bus.oDONE);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.oDONE === 1'b1 || bus.oBUSY === 1'b1) seen++;
    end
    applied++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL rst_mid_abandoned got %0d active cycles want 0", seen);
    end
    convert(16'd500, -1, 16'd0, d, b, l, bn, hb, ov);
    applied++;
    if (d !== 20'h00500 || b !== 5'b11000 || l !== 16) begin
      miscompares++;
      $display("FAIL rst_mid_recover got %h/%b lat %0d want %h/%b lat 16",
               d, b, l, 20'h00500, 5'b11000);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    applied = 0;
    miscompares = 0;
    rst_n = 1'b0;
    bus.iSTART = 1'b0;
    bus.iBIN = '0;
    test_reset();
    test_zero();
    test_1234();
    test_max();
    test_ignore_restart();
    test_back_to_back();
    test_reset_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_digit_conv.md
# bcd_digit_conv

Sequential binary-to-BCD converter that sits directly upstream of the per-digit seven-segment decoders. It accepts a binary value from the CPU display register, converts it to packed decimal digits with an iterative shift-and-add-3 (double-dabble) engine, and holds the digits plus leading-zero blank flags stable for the decoders until the next conversion completes.

## Interface
- WIDTH, 16, binary input width; 4..32.
- DIGITS, 5, BCD digits produced; must satisfy 10^DIGITS > 2^WIDTH - 1 (elaboration-time check).
- iCLK  in  1  single clock; all logic on rising edge.
- iRST_N  in  1  reset, synchronous, active-low.
- iSTART  in  1  request conversion of iBIN; sampled only in IDLE or DONE.
- iBIN  in  WIDTH  unsigned binary value; captured on the accepting edge only.
- oBUSY  out  1  high while a conversion is in progress (state SHIFT).
- oDONE  out  1  one-cycle pulse: new result valid on oDIGITS/oBLANK.
- oDIGITS  out  4*DIGITS  packed BCD; digit 0 (ones) in [3:0], digit k in [4k+3:4k].
- oBLANK  out  DIGITS  per-digit leading-zero blank flag for the downstream decoder.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: iSTART=1 -> capture iBIN into shift register, clear BCD working register, load bit counter with WIDTH, go SHIFT.
- SHIFT: each cycle, first add 3 to every working BCD nibble >= 5, then shift {bcd, bin} left by one; decrement counter. On the edge performing the last (WIDTH-th) shift: register the final BCD into oDIGITS, compute oBLANK, go DONE.
- DONE: oDONE=1 for exactly this cycle. iSTART=1 here -> accepted as in IDLE (go SHIFT); else go IDLE.
- iSTART in SHIFT is ignored (not queued); iBIN changes during SHIFT have no effect.
- oDIGITS/oBLANK change only on the edge entering DONE (or on reset); they hold across IDLE and SHIFT, so the display never shows partial results.
- oBLANK[k] = 1 iff digits k..DIGITS-1 of the result are all zero, for k >= 1; oBLANK[0] is always 0 (a value of zero shows a single "0").
- Arithmetic: add-3 per nibble is 4-bit, no carry out (nibble <= 9 before adjust, <= 12 after, never overflows). Working BCD register is 4*DIGITS bits; top bits shifted out are discarded and are guaranteed zero by the DIGITS constraint.
- Reset (any state, including mid-SHIFT): state IDLE, counter 0, oBUSY 0, oDONE 0, oDIGITS all zero, oBLANK = all ones except bit 0 (displays "0"). Any in-flight conversion is abandoned without an oDONE.

## Timing
- Start accepted at edge N -> SHIFT during cycles N+1..N+WIDTH -> oDIGITS/oBLANK updated and oDONE high in the cycle after edge N+WIDTH.
- Latency from accepting edge to oDONE: WIDTH cycles; oBUSY high for exactly WIDTH cycles.
- Back-to-back: iSTART held high continuously -> one result every WIDTH+1 cycles.
- oDONE and oBUSY are never high simultaneously.
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Shared display package: FSM state enum (IDLE/SHIFT/DONE), digit-nibble type, and the DIGITS-sufficiency check as a constant function reused by other display blocks.
- One sub-module: bcd_add3, combinational 4-bit nibble adjust (in >= 5 ? in + 3 : in), instantiated DIGITS times via generate.
- Counter width = clog2(WIDTH+1).

## Test plan
- iBIN=0, pulse iSTART -> after 16 cycles oDONE pulse, oDIGITS=0x00000, oBLANK=5'b11110.
- iBIN=1234 -> oDIGITS=0x01234, oBLANK=5'b10000; oBUSY high exactly 16 cycles.
- iBIN=65535 -> oDIGITS=0x65535, oBLANK=5'b00000; previous result held unchanged during SHIFT.
- iBIN=7, then iSTART re-pulsed with iBIN=9999 mid-SHIFT -> re-pulse ignored, result 0x00007, oBLANK=5'b11110.
- iSTART held high, iBIN=42 then 100 at the DONE cycle -> results 0x00042 then 0x00100, oDONE pulses 17 cycles apart.
- iRST_N low for one cycle at shift 8 of iBIN=500 -> no oDONE, outputs return to 0x00000/5'b11110, state IDLE; next start converts normally.
